// File: rtl/lb_dispatcher.sv
// lb_dispatcher: single-beat load-balancing dispatcher.
// Each accepted beat is offered to one output lane, chosen round-robin and
// skipping lanes flagged as blocked. A lane that stalls for STALL_MAX+1
// consecutive cycles is marked blocked, and the held beat is rerouted to the
// next unblocked lane. A blocked flag clears in any cycle its lane is ready.
// Optional statistics counters are compiled in only when LB_DISPATCH_STATS_EN
// is defined; otherwise beat_count and timeout_count are tied to zero.
module lb_dispatcher #(
  parameter int NUM_LANES  = 4,
  parameter int DATA_BITS  = 32,
  parameter int STALL_BITS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic [NUM_LANES-1:0] m_valid,
  input  logic [NUM_LANES-1:0] m_ready,
  output logic [DATA_BITS-1:0] m_data,
  output logic [NUM_LANES-1:0] blocked,
  output logic [31:0]          beat_count,
  output logic [15:0]          timeout_count
);

  localparam int LW = $clog2(NUM_LANES);
  localparam logic [STALL_BITS-1:0] STALL_MAX = '1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]           state;
  logic [LW-1:0]        ptr;
  logic [LW-1:0]        sel;
  logic [STALL_BITS-1:0] stall;
  logic [NUM_LANES-1:0] blocked_q;
  logic [NUM_LANES-1:0] blocked_next;
  logic [DATA_BITS-1:0] data_q;
  logic                 dispatch;
  logic                 timeout;

  // First unblocked lane scanning start, start+1, ... (mod NUM_LANES).
  // With skip_start the start lane itself is not a candidate. If no lane
  // qualifies the start lane is returned unchanged.
  function automatic logic [LW-1:0] next_free(input logic [LW-1:0]        start,
                                               input logic [NUM_LANES-1:0] blk,
                                               input logic                 skip_start);
    logic [LW-1:0] res;
    logic [LW-1:0] cand;
    int            idx;
    res = start;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx  = (int'(start) + k) % NUM_LANES;
      cand = LW'(idx);
      if (!blk[cand] && !(skip_start && (k == 0))) begin
        res = cand;
      end
    end
    return res;
  endfunction

  // Lane index after l, wrapping for any NUM_LANES.
  function automatic logic [LW-1:0] wrap_inc(input logic [LW-1:0] l);
    return (l == LW'(NUM_LANES - 1)) ? '0 : l + LW'(1);
  endfunction

  assign dispatch = (state == HOLD) && m_ready[sel];
  assign timeout  = (state == HOLD) && !m_ready[sel] && (stall == STALL_MAX);

  // Blocked flags: any ready lane clears its flag; a timeout flags the selected lane.
  always_comb begin
    blocked_next = blocked_q & ~m_ready;
    if (timeout) begin
      blocked_next[sel] = 1'b1;
    end else begin
      blocked_next = blocked_next;
    end
  end

  // Dispatcher state: accept, hold, reroute on timeout, and release on handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      ptr       <= '0;
      sel       <= '0;
      stall     <= '0;
      blocked_q <= '0;
      data_q    <= '0;
    end else begin
      blocked_q <= blocked_next;
      case (state)
        IDLE: begin
          if (s_valid) begin
            data_q <= s_data;
            state  <= HOLD;
            stall  <= '0;
            sel    <= next_free(ptr, blocked_q, 1'b0);
          end
        end
        HOLD: begin
          if (m_ready[sel]) begin
            state <= IDLE;
            ptr   <= wrap_inc(sel);
          end else if (stall == STALL_MAX) begin
            stall <= '0;
            sel   <= next_free(sel, blocked_q, 1'b1);
          end else begin
            stall <= stall + STALL_BITS'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // One-hot lane offer while a beat is held.
  always_comb begin
    m_valid = '0;
    if (state == HOLD) begin
      m_valid[sel] = 1'b1;
    end else begin
      m_valid = '0;
    end
  end

  assign s_ready = (state == IDLE) && !reset;
  assign m_data  = data_q;
  assign blocked = blocked_q;

`ifdef LB_DISPATCH_STATS_EN
  logic [31:0] beat_count_q;
  logic [15:0] timeout_count_q;

  // Statistics: wrapping dispatch count and saturating timeout count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_count_q    <= 32'd0;
      timeout_count_q <= 16'd0;
    end else begin
      if (dispatch) begin
        beat_count_q <= beat_count_q + 32'd1;
      end
      if (timeout && (timeout_count_q != 16'hFFFF)) begin
        timeout_count_q <= timeout_count_q + 16'd1;
      end
    end
  end

  assign beat_count    = beat_count_q;
  assign timeout_count = timeout_count_q;
`else
  assign beat_count    = 32'd0;
  assign timeout_count = 16'd0;
`endif

endmodule

// File: doc/lb_dispatcher.md
LB_DISPATCHER -- requirements
Module: lb_dispatcher

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of output lanes (2..16).
REQ-002 SHALL have parameter DATA_BITS, default 32, beat payload width.
REQ-003 SHALL have parameter STALL_BITS, default 3, stall counter width; STALL_MAX = 2**STALL_BITS - 1.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have ports s_valid in 1, s_ready out 1, s_data in DATA_BITS: upstream valid/ready beat input.
REQ-007 SHALL have ports m_valid out NUM_LANES, m_ready in NUM_LANES, m_data out DATA_BITS (shared by all lanes).
REQ-008 SHALL have port blocked, output, NUM_LANES, per-lane timed-out flag.
REQ-009 SHALL have ports beat_count out 32 and timeout_count out 16, statistics (see Configuration).

Function
REQ-010 SHALL implement two states: IDLE (no beat held) and HOLD (one beat held in data register).
REQ-011 SHALL drive s_ready = 1 exactly when state is IDLE; max throughput one beat per two cycles.
REQ-012 SHALL, on s_valid && s_ready, latch s_data, enter HOLD, clear stall counter, and set sel = first lane with blocked=0 scanning ptr, ptr+1, ... modulo NUM_LANES; if all lanes are blocked, sel = ptr.
REQ-013 SHALL drive m_valid one-hot: bit sel = 1 in HOLD, all zero in IDLE; m_data = held beat, stable throughout HOLD.
REQ-014 SHALL complete a dispatch on m_valid[sel] && m_ready[sel]: return to IDLE, ptr <= (sel+1) mod NUM_LANES.
REQ-015 SHALL increment the stall counter in each HOLD cycle without handshake while counter < STALL_MAX.
REQ-016 SHALL, in a HOLD cycle with counter == STALL_MAX and m_ready[sel] = 0, set blocked[sel], reset counter to 0, and move sel to the next lane after sel with blocked=0 (excluding sel); if none exists, sel is unchanged.
REQ-017 SHALL consider a timeout to occur after STALL_MAX+1 consecutive stalled cycles on the same lane.
REQ-018 SHALL clear blocked[i] in any cycle where m_ready[i] = 1, regardless of state or sel.
REQ-019 SHALL never drop, duplicate or alter a held beat; rerouting moves the same beat.
REQ-020 SHALL ignore m_ready on non-selected lanes except for REQ-018.
REQ-021 SHALL compute ptr and sel wrap-around modulo NUM_LANES for non-power-of-two NUM_LANES.

Reset
REQ-022 SHALL, on reset asserted, asynchronously force state IDLE, ptr 0, sel 0, stall counter 0, blocked all 0, beat_count 0, timeout_count 0, data register 0.
REQ-023 SHALL, while reset is high, drive s_ready = 0 and m_valid all 0; a beat held at reset assertion is discarded.
REQ-024 SHALL accept a beat in the first cycle after reset deassertion if s_valid = 1.

Configuration
REQ-025 SHALL compile statistics only when macro LB_DISPATCH_STATS_EN is defined.
REQ-026 SHALL, with LB_DISPATCH_STATS_EN, increment beat_count (wrapping) on every dispatch handshake and timeout_count (saturating at 16'hFFFF) on every REQ-016 timeout event.
REQ-027 SHALL, without LB_DISPATCH_STATS_EN, keep both ports present and tied to 0, with no counter flops.

Verification
REQ-028 SHALL cover round-robin: NUM_LANES=4, all m_ready=1, 8 beats 0x10..0x17 -> lanes 0,1,2,3,0,1,2,3, one beat each per two cycles.
REQ-029 SHALL cover timeout: STALL_BITS=3, m_ready[0]=0 forever, others 1, one beat 0xA5 -> m_valid[0] high 8 cycles, then blocked[0]=1, beat 0xA5 delivered on lane 1, timeout_count=1 (stats on).
REQ-030 SHALL cover skip: blocked[1]=1, ptr=1, new beat -> sel=2 immediately; blocked[1] clears the first cycle m_ready[1]=1.
REQ-031 SHALL cover all-blocked: all m_ready=0 -> sel cycles lane by lane every 8 cycles until blocked=4'b1111, then sel holds; raising m_ready[sel] completes the beat.
REQ-032 SHALL cover reset mid-HOLD: reset asserted while m_valid=4'b0100 -> m_valid=0, blocked=0, counters=0 asynchronously; next beat goes to lane 0.
REQ-033 SHALL cover NUM_LANES=3 wrap: 4 beats, all ready -> lanes 0,1,2,0.
